// File: rtl/rom_read_arbiter_if.sv
// Bundle of requester-side and ROM-side signals for the two-port ROM read arbiter.
// The arbiter uses the slave view; the surrounding logic drives the master view.
interface rom_read_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0_i;
  logic              req1_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [ADDR_W-1:0] addr1_i;
  logic              ack0_o;
  logic              ack1_o;
  logic [DATA_W-1:0] rdata_o;
  logic              busy_o;
  logic [ADDR_W-1:0] rom_address_o;
  logic              rom_ce_o;
  logic              rom_read_en_o;
  logic [DATA_W-1:0] rom_data_i;

  modport slave (
    input  req0_i, req1_i, addr0_i, addr1_i, rom_data_i,
    output ack0_o, ack1_o, rdata_o, busy_o, rom_address_o, rom_ce_o, rom_read_en_o
  );

  modport master (
    output req0_i, req1_i, addr0_i, addr1_i, rom_data_i,
    input  ack0_o, ack1_o, rdata_o, busy_o, rom_address_o, rom_ce_o, rom_read_en_o
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between two requesters.
// Each read holds ce/read_en for WAIT_CYCLES cycles, registers the data, then acks.
module rom_read_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  rom_read_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              gnt_id_reg;
  logic              last_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              load_grant;
  logic              capture;
  logic              busy;
  logic              strobe;
  logic              winner;
  logic [1:0]        req_vec;
  logic [1:0]        ack_vec;
  logic [ADDR_W-1:0] addr_in [2];

  assign req_vec    = {bus.req1_i, bus.req0_i};
  assign addr_in[0] = bus.addr0_i;
  assign addr_in[1] = bus.addr1_i;

  // Under contention the port that was not served last wins.
  assign winner = (&req_vec) ? ~last_reg : req_vec[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_grant = 1'b0;
    capture    = 1'b0;
    busy       = 1'b1;
    strobe     = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (|req_vec) begin
          load_grant = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        strobe = 1'b1;
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_id_reg <= 1'b0;
      last_reg   <= 1'b1;
      addr_reg   <= '0;
      cnt_reg    <= '0;
      rdata_reg  <= '0;
    end else if (load_grant) begin
      gnt_id_reg <= winner;
      addr_reg   <= addr_in[winner];
      cnt_reg    <= CNT_LOAD;
    end else if (capture) begin
      rdata_reg <= bus.rom_data_i;
      last_reg  <= gnt_id_reg;
    end else if (strobe) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = (state_reg == ACK) && (gnt_id_reg == 1'(gi));
    end
  endgenerate

  assign bus.ack0_o        = ack_vec[0];
  assign bus.ack1_o        = ack_vec[1];
  assign bus.rdata_o       = rdata_reg;
  assign bus.busy_o        = busy;
  assign bus.rom_ce_o      = strobe;
  assign bus.rom_read_en_o = strobe;
  assign bus.rom_address_o = strobe ? addr_reg : '0;
endmodule
